// File: rtl/multiplier_arbiter.sv
// Round-robin front end that shares one sequential multiplier among NREQ requesters.
// Grants one requester at a time, starts the multiplier, and returns the product or a watchdog error.
module multiplier_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_multiplier,
  input  logic [NREQ*WIDTH-1:0] req_multiplicand,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]    resp_product,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_multiplier,
  output logic [WIDTH-1:0]      mul_multiplicand,
  input  logic [2*WIDTH-1:0]    mul_product,
  input  logic                  mul_done,
  output logic [1:0]            dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  // Handshake: req is a level held until gnt; gnt is a one-cycle pulse meaning the
  // operands were captured, after which the requester may drop req or change operands.
  // resp_valid is a one-cycle pulse with no back-pressure; resp_product/resp_err hold after it.

  // Scan offsets from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin : rr_pick
    int idx;
    win_nxt = last;
    a_nxt   = '0;
    b_nxt   = '0;
    idx     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(last) + 1 + i;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == idx)) begin
          win_nxt = IW'(j);
          a_nxt   = req_multiplier[j*WIDTH +: WIDTH];
          b_nxt   = req_multiplicand[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      last             <= LAST_RST;
      win              <= '0;
      cnt              <= '0;
      gnt              <= '0;
      resp_valid       <= '0;
      resp_product     <= '0;
      resp_err         <= 1'b0;
      busy             <= 1'b0;
      mul_start        <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      mul_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            win              <= win_nxt;
            mul_multiplier   <= a_nxt;
            mul_multiplicand <= b_nxt;
            gnt[win_nxt]     <= 1'b1;
            mul_start        <= 1'b1;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        // mul_done may still be high from the previous operation, so it is not sampled here.
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            resp_product    <= mul_product;
            resp_err        <= 1'b0;
            resp_valid[win] <= 1'b1;
            state           <= RESP;
          end else if (cnt == CNT_MAX) begin
            resp_product    <= '0;
            resp_err        <= 1'b1;
            resp_valid[win] <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last  <= win;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: a fixed-latency multiplier model, a response scoreboard,
// a table of single-request vectors and hand-written multi-cycle sequences.
module tb_multiplier_arbiter;

  localparam int WIDTH   = 4;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;
  localparam int MUL_LAT = 7;  // edges from the edge sampling mul_start to the edge raising done
  localparam int EW      = NREQ + 1 + 2*WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_multiplier = '0;
  logic [NREQ*WIDTH-1:0] req_multiplicand = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       resp_valid;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  resp_err;
  logic                  busy;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_multiplier;
  logic [WIDTH-1:0]      mul_multiplicand;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  mul_done;
  logic [1:0]            dbg_state;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic hang = 1'b0;
  logic [EW-1:0] exp_q[$];

  multiplier_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .gnt(gnt), .resp_valid(resp_valid), .resp_product(resp_product), .resp_err(resp_err),
    .busy(busy), .mul_start(mul_start),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .mul_done(mul_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  // Multiplier model: done stays high until the next start, product is junk while not done.
  logic [2*WIDTH-1:0] m_prod;
  logic               m_done;
  int                 m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prod <= '0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (mul_start) begin
      m_prod <= {4'b0, mul_multiplier} * {4'b0, mul_multiplicand};
      m_done <= 1'b0;
      m_cnt  <= MUL_LAT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !hang) m_done <= 1'b1;
    end
  end
  assign mul_done    = m_done;
  assign mul_product = m_done ? m_prod : 8'hA5;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : scoreboard
    logic [EW-1:0] e;
    if (rst) begin
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_scoreboard", 32'({resp_valid, resp_err, resp_product}), 32'(e));
        end
      end
      if (gnt != '0 || resp_valid != '0) begin
        check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        check("resp_onehot", 32'($onehot0(resp_valid)), 32'd1);
        check("gnt_resp_exclusive", 32'((gnt != '0) && (resp_valid != '0)), 32'd0);
      end
      if (gnt != '0) check("start_with_gnt", 32'(mul_start), 32'd1);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [NREQ-1:0] r, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                       input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    req              = r;
    req_multiplier   = {a1, a0};
    req_multiplicand = {b1, b0};
  endtask

  task automatic push_exp(input logic [NREQ-1:0] v, input logic err, input logic [2*WIDTH-1:0] p);
    exp_q.push_back({v, err, p});
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g, output int t);
    g = '0;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        t = cyc;
        break;
      end
    end
    if (t < 0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(output logic [NREQ-1:0] v, output int t);
    v = '0;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        v = resp_valid;
        t = cyc;
        break;
      end
    end
    if (t < 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [NREQ-1:0]    r;
    logic [WIDTH-1:0]   a0, b0, a1, b1;
    logic [NREQ-1:0]    exp_gnt;
    logic [2*WIDTH-1:0] exp_prod;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    logic [NREQ-1:0] g, rv;
    logic [WIDTH-1:0] ea, eb;
    int tg, tg2, tr, c, seen;

    vecs[0] = '{r: 2'b01, a0: 4'd13, b0: 4'd11, a1: 4'd2,  b1: 4'd2,  exp_gnt: 2'b01, exp_prod: 8'd143};
    vecs[1] = '{r: 2'b10, a0: 4'd1,  b0: 4'd1,  a1: 4'd5,  b1: 4'd6,  exp_gnt: 2'b10, exp_prod: 8'd30};
    vecs[2] = '{r: 2'b01, a0: 4'd15, b0: 4'd15, a1: 4'd3,  b1: 4'd3,  exp_gnt: 2'b01, exp_prod: 8'd225};
    vecs[3] = '{r: 2'b10, a0: 4'd7,  b0: 4'd7,  a1: 4'd0,  b1: 4'd9,  exp_gnt: 2'b10, exp_prod: 8'd0};
    vecs[4] = '{r: 2'b01, a0: 4'd15, b0: 4'd1,  a1: 4'd4,  b1: 4'd4,  exp_gnt: 2'b01, exp_prod: 8'd15};
    vecs[5] = '{r: 2'b10, a0: 4'd3,  b0: 4'd3,  a1: 4'd8,  b1: 4'd8,  exp_gnt: 2'b10, exp_prod: 8'd64};

    drive('0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_product", 32'(resp_product), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mul_a", 32'(mul_multiplier), 32'd0);
    check("rst_mul_b", 32'(mul_multiplicand), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single-request vectors; the last one is requester 1 so requester 0 leads contention.
    foreach (vecs[i]) begin
      push_exp(vecs[i].exp_gnt, 1'b0, vecs[i].exp_prod);
      drive(vecs[i].r, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      c  = cyc;
      ea = vecs[i].exp_gnt[0] ? vecs[i].a0 : vecs[i].a1;
      eb = vecs[i].exp_gnt[0] ? vecs[i].b0 : vecs[i].b1;
      wait_gnt(g, tg);
      check("vec_gnt", 32'(g), 32'(vecs[i].exp_gnt));
      check("vec_gnt_latency", 32'(tg - c), 32'd1);
      check("vec_busy_at_gnt", 32'(busy), 32'd1);
      check("vec_operand_a", 32'(mul_multiplier), 32'(ea));
      check("vec_operand_b", 32'(mul_multiplicand), 32'(eb));
      @(negedge clk);
      drive('0, 0, 0, 0, 0);
      wait_resp(rv, tr);
      check("vec_resp_valid", 32'(rv), 32'(vecs[i].exp_gnt));
      check("vec_latency", 32'(tr - c), 32'(3 + MUL_LAT));
      repeat (2) @(negedge clk);
      check("vec_product_hold", 32'(resp_product), 32'(vecs[i].exp_prod));
      check("vec_idle_state", 32'(dbg_state), 32'd0);
      check("vec_idle_busy", 32'(busy), 32'd0);
    end

    // Contention: both requesters held, grants must alternate.
    push_exp(2'b01, 1'b0, 8'd225);
    push_exp(2'b10, 1'b0, 8'd6);
    push_exp(2'b01, 1'b0, 8'd225);
    drive(2'b11, 4'd15, 4'd15, 4'd2, 4'd3);
    c = cyc;
    wait_gnt(g, tg);
    check("cont_gnt0", 32'(g), 32'b01);
    check("cont_gnt0_latency", 32'(tg - c), 32'd1);
    wait_gnt(g, tg2);
    check("cont_gnt1", 32'(g), 32'b10);
    check("cont_period1", 32'(tg2 - tg), 32'(MUL_LAT + 4));
    wait_gnt(g, tg);
    check("cont_gnt2", 32'(g), 32'b01);
    check("cont_period2", 32'(tg - tg2), 32'(MUL_LAT + 4));
    @(negedge clk);
    drive('0, 0, 0, 0, 0);
    wait_resp(rv, tr);
    check("cont_last_resp", 32'(rv), 32'b01);

    // Early withdrawal: requester 1 pulses req while requester 0 is in WAIT.
    repeat (2) @(negedge clk);
    push_exp(2'b01, 1'b0, 8'd12);
    drive(2'b01, 4'd3, 4'd4, 4'd9, 4'd9);
    wait_gnt(g, tg);
    check("wd_gnt", 32'(g), 32'b01);
    @(negedge clk);
    drive(2'b10, 4'd3, 4'd4, 4'd9, 4'd9);
    repeat (3) @(negedge clk);
    drive('0, 0, 0, 0, 0);
    wait_resp(rv, tr);
    check("wd_resp", 32'(rv), 32'b01);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (gnt != '0) seen++;
    end
    check("wd_no_gnt", 32'(seen), 32'd0);
    check("wd_idle_state", 32'(dbg_state), 32'd0);
    check("wd_idle_busy", 32'(busy), 32'd0);

    // Operand change in the cycle after gnt must not affect the product.
    push_exp(2'b01, 1'b0, 8'd63);
    drive(2'b01, 4'd7, 4'd9, 4'd0, 4'd0);
    wait_gnt(g, tg);
    check("opchg_gnt", 32'(g), 32'b01);
    @(negedge clk);
    drive(2'b00, 4'd3, 4'd9, 4'd0, 4'd0);
    check("opchg_mul_a_held", 32'(mul_multiplier), 32'd7);
    wait_resp(rv, tr);
    check("opchg_resp", 32'(rv), 32'b01);

    // Watchdog: multiplier never signals done.
    hang = 1'b1;
    push_exp(2'b10, 1'b1, 8'd0);
    drive(2'b10, 4'd0, 4'd0, 4'd5, 4'd5);
    wait_gnt(g, tg);
    check("wdog_gnt", 32'(g), 32'b10);
    @(negedge clk);
    drive('0, 0, 0, 0, 0);
    wait_resp(rv, tr);
    check("wdog_resp", 32'(rv), 32'b10);
    check("wdog_resp_time", 32'(tr - tg), 32'(TIMEOUT + 1));
    check("wdog_err", 32'(resp_err), 32'd1);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(2'b01, 1'b0, 8'd42);
    drive(2'b01, 4'd6, 4'd7, 4'd0, 4'd0);
    c = cyc;
    wait_gnt(g, tg);
    check("wdog_next_gnt", 32'(g), 32'b01);
    @(negedge clk);
    drive('0, 0, 0, 0, 0);
    wait_resp(rv, tr);
    check("wdog_next_latency", 32'(tr - c), 32'(3 + MUL_LAT));
    check("wdog_next_err", 32'(resp_err), 32'd0);

    // Reset in the middle of WAIT drops the operation.
    repeat (2) @(negedge clk);
    drive(2'b01, 4'd9, 4'd9, 4'd0, 4'd0);
    wait_gnt(g, tg);
    check("mrst_gnt", 32'(g), 32'b01);
    @(negedge clk);
    drive('0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("mrst_in_wait", 32'(dbg_state), 32'd2);
    rst = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'd0);
    check("mrst_product", 32'(resp_product), 32'd0);
    check("mrst_mul_a", 32'(mul_multiplier), 32'd0);
    check("mrst_mul_b", 32'(mul_multiplicand), 32'd0);
    check("mrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (MUL_LAT + 6) @(negedge clk);
    push_exp(2'b01, 1'b0, 8'd2);
    push_exp(2'b10, 1'b0, 8'd12);
    drive(2'b11, 4'd1, 4'd2, 4'd3, 4'd4);
    wait_gnt(g, tg);
    check("mrst_first_winner", 32'(g), 32'b01);
    @(negedge clk);
    drive(2'b10, 4'd1, 4'd2, 4'd3, 4'd4);
    wait_gnt(g, tg);
    check("mrst_second_winner", 32'(g), 32'b10);
    @(negedge clk);
    drive('0, 0, 0, 0, 0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Round-robin arbiter and sequencer that shares one constant-time sequential multiplier (`Multiplier_StateBranch`) among `NREQ` requesters. It captures the winning requester's operands, pulses the multiplier's `start`, waits for `productDone`, and returns the product to the winner with a one-cycle valid pulse. A watchdog turns a hung multiplier into an error response instead of a deadlock. It sits between requester logic and a single multiplier instance in the integration top.

## Interface
- `WIDTH`, 4, operand width; product is `2*WIDTH`
- `NREQ`, 2, number of requesters (2..8)
- `TIMEOUT`, 64, maximum cycles in WAIT before an error response (≥ 2*WIDTH+4)
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: asynchronous, active-low reset
- `req` input NREQ: request level, one bit per requester
- `req_multiplier` input NREQ*WIDTH: operand A; slice i = bits [i*WIDTH +: WIDTH]
- `req_multiplicand` input NREQ*WIDTH: operand B, same slicing
- `gnt` output NREQ: one-hot, one-cycle pulse; operands of that requester are captured
- `resp_valid` output NREQ: one-hot, one-cycle pulse; result ready for that requester
- `resp_product` output 2*WIDTH: product, valid with `resp_valid` and held until the next response
- `resp_err` output 1: qualifies `resp_valid`; 1 means watchdog timeout, product forced to 0
- `busy` output 1: high in every state except IDLE
- `mul_start` output 1: multiplier start, one-cycle pulse
- `mul_multiplier`, `mul_multiplicand` output WIDTH: captured operands to the multiplier
- `mul_product` input 2*WIDTH: multiplier product
- `mul_done` input 1: multiplier `productDone`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` bit is set, pick the winner by round robin, starting at index `(last+1) mod NREQ`. Capture the winner's operand slices, register the winner index, and go to ISSUE. With no requests, stay in IDLE.
- ISSUE, one cycle: `gnt[win]`=1 and `mul_start`=1. Operands drive `mul_*` from the capture registers. Clear the watchdog counter and go to WAIT. `mul_done` is ignored in ISSUE because it may be stale from the previous operation.
- WAIT:
  - On the first cycle `mul_done`=1, latch `mul_product` into `resp_product`, set `resp_err`=0, and go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1` without done, set `resp_product`=0 and `resp_err`=1, then go to RESP.
- RESP, one cycle: `resp_valid[win]`=1, set `last`=win, go to IDLE.
- Requester rules:
  - A requester may drop `req` or change its operands from the cycle after its `gnt`.
  - A `req` that drops before it is granted is never served.
  - A requester holding `req` after its `resp_valid` is treated as a new request and competes normally.
- `mul_multiplier` and `mul_multiplicand` hold their captured values until the next capture, so the multiplier sees stable operands for the whole operation.
- No arithmetic is done here; the product passes through unchanged, full `2*WIDTH` bits.
- Reset (asynchronous, `rst`=0) forces:
  - state IDLE, `last`=NREQ-1 (so requester 0 has first priority);
  - all outputs 0, capture registers 0, counter 0.
- Reset in the middle of an operation drops that operation: no `resp_valid` is issued. The multiplier shares the same reset; the integration top inverts it for the multiplier's active-high `rst`.

## Timing
- A `req` seen in IDLE at edge t gives `gnt` and `mul_start` in cycle t+1.
- With `mul_done` first high in WAIT cycle d, `resp_valid` is high in cycle d+1 and the arbiter is back in IDLE at d+2.
- Minimum request-to-response latency = 3 + multiplier latency (constant for this multiplier).
- Back-to-back throughput: one operation per (multiplier latency + 4) cycles; IDLE always lasts at least one cycle.
- `gnt`, `resp_valid`, `mul_start` and `busy` are all registered outputs; none is combinational from inputs.
- At most one bit of `gnt` and of `resp_valid` is ever set. `gnt` and `resp_valid` are never high in the same cycle.

## Test plan
- Single request: NREQ=2, WIDTH=4, `req`=01 with A=13, B=11 → `gnt`=01 one cycle after the request, `resp_valid`=01 with `resp_product`=143 and `resp_err`=0; latency equals 3 + multiplier latency.
- Contention: `req`=11 held continuously, A0=15, B0=15, A1=2, B1=3 → grants alternate 01, 10, 01; products 225, 6, 225; no requester is granted twice in a row.
- Early withdrawal: requester 1 asserts `req` while requester 0 is in WAIT, then drops it before RESP → requester 1 never sees `gnt`; the arbiter returns to IDLE and stays there.
- Operand change after grant: requester 0 changes A from 7 to 3 in the cycle after `gnt`, with B=9 → `resp_product`=63.
- Watchdog: `mul_done` tied 0 with TIMEOUT=64 → `resp_valid` comes TIMEOUT cycles after WAIT entry with `resp_err`=1 and `resp_product`=0; the next request is served normally.
- Reset mid-WAIT: `rst` pulsed low → all outputs go 0 immediately, no `resp_valid` is issued, and after release requester 0 wins a simultaneous `req`=11.
